// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: AB state constants,
// transition classes and the transition classifier.
package quad_pkg;

    localparam int unsigned AB_W = 2;

    localparam logic [AB_W-1:0] S00 = 2'b00;
    localparam logic [AB_W-1:0] S01 = 2'b01;
    localparam logic [AB_W-1:0] S11 = 2'b11;
    localparam logic [AB_W-1:0] S10 = 2'b10;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        INC     = 2'd1,
        DEC     = 2'd2,
        ILLEGAL = 2'd3
    } trans_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change is reverse.
    function automatic trans_t classify(input logic [AB_W-1:0] prev,
                                        input logic [AB_W-1:0] cur);
        logic [AB_W-1:0] fwd;
        trans_t          res;
        case (prev)
            S00:     fwd = S01;
            S01:     fwd = S11;
            S11:     fwd = S10;
            default: fwd = S00;
        endcase
        if (cur == prev) begin
            res = NONE;
        end else if (cur == (prev ^ 2'b11)) begin
            res = ILLEGAL;
        end else if (cur == fwd) begin
            res = INC;
        end else begin
            res = DEC;
        end
        return res;
    endfunction

endpackage

// File: rtl/quad_period_timer.sv
// Saturating step-period timer; built only when QUAD_PERIOD_EN is defined.
`ifdef QUAD_PERIOD_EN
module quad_period_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                step_evt,
    output logic [PERIOD_W-1:0] period
);

    localparam logic [PERIOD_W-1:0] PMAX = '1;

    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] pcnt_inc;

    // pcnt+1, held at the ceiling once reached
    always_comb begin
        pcnt_inc = (pcnt == PMAX) ? PMAX : pcnt + PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pcnt   <= '0;
            period <= '0;
        end else if (step_evt) begin
            period <= pcnt_inc;
            pcnt   <= '0;
        end else begin
            pcnt   <= pcnt_inc;
        end
    end

endmodule
`endif

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: wrapping position count, step/dir pulse and sticky error.
// Define QUAD_PERIOD_EN to build the step-period timer; otherwise period is 0.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned X1_MODE  = 0,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a,
    input  logic                b,
    input  logic                clear,
    input  logic                err_clr,
    output logic [WIDTH-1:0]    count,
    output logic                step,
    output logic                dir,
    output logic                err,
    output logic [PERIOD_W-1:0] period
);

    logic [AB_W-1:0] prev_ab;
    logic [AB_W-1:0] cur_ab;
    logic            valid;
    trans_t          trans;
    logic            counted;
    logic            up;

    // Classify this cycle's AB change and decide whether it moves the count
    always_comb begin
        cur_ab  = {a, b};
        trans   = valid ? classify(prev_ab, cur_ab) : NONE;
        up      = (trans == INC);
        counted = 1'b0;
        if (trans == INC || trans == DEC) begin
            counted = (X1_MODE == 0) ? 1'b1 : (cur_ab == S00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_ab <= S00;
            valid   <= 1'b0;
            count   <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev_ab <= cur_ab;
            valid   <= 1'b1;
            step    <= 1'b0;
            // A new illegal transition outranks a clear request
            if (trans == ILLEGAL) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if (clear) begin
                count <= '0;
            end else if (counted) begin
                count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
                step  <= 1'b1;
                dir   <= up;
            end
        end
    end

`ifdef QUAD_PERIOD_EN
    quad_period_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_period_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .step_evt (counted && !clear),
        .period   (period)
    );
`else
    assign period = '0;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: x4 and x1 instances share stimulus and are
// checked every cycle against a Gray-index position model.
module tb_quad_step_decoder;

    localparam int unsigned W    = 8;
    localparam int unsigned PW   = 4;
    localparam int          PMAX = (1 << PW) - 1;
    localparam int          CMSK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          clear = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  count0, count1;
    logic          step0, step1, dir0, dir1, err0, err1;
    logic [PW-1:0] period0, period1;

    always #5 clk = ~clk;

    quad_step_decoder #(.WIDTH(W), .X1_MODE(0), .PERIOD_W(PW)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .count(count0), .step(step0), .dir(dir0), .err(err0), .period(period0)
    );

    quad_step_decoder #(.WIDTH(W), .X1_MODE(1), .PERIOD_W(PW)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
        .count(count1), .step(step1), .dir(dir1), .err(err1), .period(period1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: position is an unbounded integer, transitions are
    // classified by the distance between Gray-code indices.
    int   cyc = 0;
    bit   m_valid = 1'b0;
    int   m_prev = 0;
    bit   m_err = 1'b0;
    int   m_pos [2];
    bit   m_step [2];
    bit   m_dir [2];
    int   m_per [2];
    int   m_ev [2];

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_update();
        int  cur;
        int  d;
        bit  counted;
        cyc++;
        cur = gidx({a, b});
        if (!rst_n) begin
            m_valid = 1'b0;
            m_prev  = 0;
            m_err   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = 0; m_step[i] = 1'b0; m_dir[i] = 1'b0;
                m_per[i] = 0; m_ev[i] = cyc;
            end
        end else begin
            d = m_valid ? ((cur - m_prev + 4) % 4) : 0;
            for (int i = 0; i < 2; i++) begin
                counted = (d == 1 || d == 3) && (i == 0 || cur == 0);
                m_step[i] = 1'b0;
                if (clear) begin
                    m_pos[i] = 0;
                    m_per[i] = 0;
                    m_ev[i]  = cyc;
                end else if (counted) begin
                    m_pos[i] = m_pos[i] + ((d == 1) ? 1 : -1);
                    m_step[i] = 1'b1;
                    m_dir[i]  = (d == 1);
                    m_per[i]  = (cyc - m_ev[i] > PMAX) ? PMAX : cyc - m_ev[i];
                    m_ev[i]   = cyc;
                end
            end
            if (d == 2) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_prev  = cur;
            m_valid = 1'b1;
        end
    endtask

    function automatic int exp_period(input int i);
`ifdef QUAD_PERIOD_EN
        return m_per[i];
`else
        return (i < 0) ? 1 : 0;
`endif
    endfunction

    always @(posedge clk) begin
        model_update();
        #1;
        chk("count0", int'(count0), m_pos[0] & CMSK);
        chk("count1", int'(count1), m_pos[1] & CMSK);
        chk("step0", int'(step0), int'(m_step[0]));
        chk("step1", int'(step1), int'(m_step[1]));
        chk("dir0", int'(dir0), int'(m_dir[0]));
        chk("dir1", int'(dir1), int'(m_dir[1]));
        chk("err0", int'(err0), int'(m_err));
        chk("err1", int'(err1), int'(m_err));
        chk("period0", int'(period0), exp_period(0));
        chk("period1", int'(period1), exp_period(1));
    end

    int steps0 = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            steps0 += int'(step0);
        end
    endtask

    task automatic drive(input logic [1:0] ab, input int n);
        {a, b} = ab;
        tick(n);
    endtask

    logic [1:0] gray [4];
    int gi;
    int r;

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

        // Reset
        rst_n = 1'b0; {a, b} = 2'b00;
        tick(3);
        chk("rst_count", int'(count0), 0);
        chk("rst_err", int'(err0), 0);
        rst_n = 1'b1;

        // Forward full cycle, two cycles per state
        steps0 = 0;
        drive(2'b00, 2); drive(2'b01, 2); drive(2'b11, 2); drive(2'b10, 2); drive(2'b00, 2);
        chk("fwd_count", int'(count0), 4);
        chk("fwd_steps", steps0, 4);
        chk("fwd_dir", int'(dir0), 1);
        chk("fwd_x1_count", int'(count1), 1);

        // Reverse full cycle from zero
        clear = 1'b1; tick(1); clear = 1'b0;
        drive(2'b10, 2); drive(2'b11, 2); drive(2'b01, 2); drive(2'b00, 2);
        chk("rev_count", int'(count0), 8'hFC);
        chk("rev_dir", int'(dir0), 0);
        chk("rev_x1_count", int'(count1), 8'hFF);

        // Illegal jump, then err_clr racing another illegal jump
        drive(2'b11, 1);
        chk("ill_err", int'(err0), 1);
        chk("ill_step", int'(step0), 0);
        chk("ill_count", int'(count0), 8'hFC);
        drive(2'b01, 1);
        err_clr = 1'b1;
        drive(2'b10, 1);
        chk("errclr_set_wins", int'(err0), 1);
        drive(2'b10, 1);
        chk("errclr", int'(err0), 0);
        err_clr = 1'b0;

        // Clear beats a simultaneous forward transition
        clear = 1'b1; tick(1); clear = 1'b0;
        drive(2'b00, 1); drive(2'b01, 1); drive(2'b11, 1); drive(2'b10, 1); drive(2'b00, 1);
        chk("pre_clr_count", int'(count0), 5);
        clear = 1'b1;
        drive(2'b01, 1);
        chk("clr_count", int'(count0), 0);
        chk("clr_step", int'(step0), 0);
        clear = 1'b0;
        drive(2'b11, 1);
        chk("post_clr_count", int'(count0), 1);

        // Reset with 11 held: first cycle only captures the state
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        tick(1);
        chk("hold11_step", int'(step0), 0);
        chk("hold11_err", int'(err0), 0);
        drive(2'b10, 1);
        chk("hold11_count", int'(count0), 1);
        chk("hold11_stepped", int'(step0), 1);

`ifdef QUAD_PERIOD_EN
        rst_n = 1'b0; {a, b} = 2'b00; tick(2); rst_n = 1'b1;
        tick(1);
        drive(2'b01, 10);
        drive(2'b11, 1);
        chk("period_10", int'(period0), 10);
        tick(39);
        drive(2'b10, 1);
        chk("period_sat", int'(period0), 15);
`endif

        // Randomized walk with holds, illegal jumps, clears and resets
        gi = gidx({a, b});
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35) begin
                // hold
            end else if (r < 62) begin
                gi = (gi + 1) % 4;
            end else if (r < 89) begin
                gi = (gi + 3) % 4;
            end else if (r < 92) begin
                gi = (gi + 2) % 4;
            end
            {a, b}  = gray[gi];
            clear   = ($urandom_range(0, 99) < 3);
            err_clr = ($urandom_range(0, 99) < 6);
            rst_n   = ($urandom_range(0, 299) != 0);
            if (r >= 97) tick(int'($urandom_range(10, 40)));
            else tick(1);
        end
        rst_n = 1'b1; clear = 1'b0; err_clr = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
